// File: rtl/l2_mem_responder_pkg.sv
// Shared types for the L2 line-to-word memory responder.
package l2_mem_responder_pkg;

    localparam int LC3B_WORDS_PER_LINE = 8;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_c_line;
    typedef logic [2:0]   lc3b_line_idx;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RESPOND,
        DONE
    } lc3b_resp_state;

    // Byte address of word idx inside the line starting at base.
    // The base is 16-byte aligned, so this never carries out of bit 3.
    function automatic lc3b_word line_word_address(lc3b_word base, lc3b_line_idx idx);
        return base + lc3b_word'({idx, 1'b0});
    endfunction

endpackage

// File: rtl/l2_mem_responder_if.sv
// Line-request bus (from the arbiter / L2) and word-wide physical memory port.
interface l2_mem_responder_if;
    import l2_mem_responder_pkg::*;

    // Line side
    lc3b_word   mem_address;
    logic       mem_read;
    logic       mem_write;
    lc3b_c_line mem_wdata;
    logic       mem_resp;
    lc3b_c_line mem_rdata;

    // Word side
    lc3b_word   word_address;
    logic       word_read;
    logic       word_write;
    lc3b_word   word_wdata;
    logic       word_resp;
    lc3b_word   word_rdata;

    // Environment view: issues line requests, serves word requests.
    modport master (
        output mem_address, mem_read, mem_write, mem_wdata,
        input  mem_resp, mem_rdata,
        input  word_address, word_read, word_write, word_wdata,
        output word_resp, word_rdata
    );

    // Responder view.
    modport slave (
        input  mem_address, mem_read, mem_write, mem_wdata,
        output mem_resp, mem_rdata,
        output word_address, word_read, word_write, word_wdata,
        input  word_resp, word_rdata
    );

endinterface

// File: rtl/l2_mem_responder_control.sv
// Sequencer for the line responder: walks eight word transactions per line
// and produces the load/store strobes for the datapath.
module l2_mem_responder_control
    import l2_mem_responder_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_mem_read,
    input  logic         i_mem_write,
    input  logic         i_word_resp,
    output lc3b_line_idx o_idx,
    output logic         o_load_req,
    output logic         o_load_wdata,
    output logic         o_store_word,
    output logic         o_word_read,
    output logic         o_word_write,
    output logic         o_mem_resp
);

    lc3b_resp_state r_state;
    lc3b_resp_state w_next_state;
    lc3b_line_idx   r_idx;
    logic           w_idx_clr;
    logic           w_idx_inc;
    logic           w_last;

    assign w_last = (r_idx == lc3b_line_idx'(LC3B_WORDS_PER_LINE - 1));
    assign o_idx  = r_idx;

    // State register and word counter.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of evaluation order.
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    // Next-state decode and word-port / completion outputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave a signal unassigned and infer a latch.
        w_next_state = r_state;
        w_idx_clr    = 1'b0;
        w_idx_inc    = 1'b0;
        o_load_req   = 1'b0;
        o_load_wdata = 1'b0;
        o_store_word = 1'b0;
        o_word_read  = 1'b0;
        o_word_write = 1'b0;
        o_mem_resp   = 1'b0;

        case (r_state)
            IDLE: begin
                // Write wins when both requests are present.
                if (i_mem_write) begin
                    o_load_req   = 1'b1;
                    o_load_wdata = 1'b1;
                    w_idx_clr    = 1'b1;
                    w_next_state = WRITE;
                end else if (i_mem_read) begin
                    o_load_req   = 1'b1;
                    w_idx_clr    = 1'b1;
                    w_next_state = READ;
                end
            end
            READ: begin
                o_word_read = 1'b1;
                if (i_word_resp) begin
                    o_store_word = 1'b1;
                    if (w_last) begin
                        w_next_state = RESPOND;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
            end
            WRITE: begin
                o_word_write = 1'b1;
                if (i_word_resp) begin
                    if (w_last) begin
                        w_next_state = RESPOND;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
            end
            RESPOND: begin
                o_mem_resp   = 1'b1;
                w_next_state = DONE;
            end
            DONE: begin
                // One dead cycle so a requester that drops its request a
                // cycle late is not accepted twice.
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/l2_mem_responder.sv
// Responder for 128-bit line requests: serializes each line into eight
// 16-bit word transactions and assembles read data into a line buffer.
module l2_mem_responder
    import l2_mem_responder_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    l2_mem_responder_if.slave  bus
);

    lc3b_line_idx w_idx;
    logic         w_load_req;
    logic         w_load_wdata;
    logic         w_store_word;
    logic         w_word_read;
    logic         w_word_write;
    logic         w_mem_resp;
    lc3b_word     w_line_base;

    lc3b_word     r_base;
    lc3b_c_line   r_wdata;
    lc3b_c_line   r_buffer;

    l2_mem_responder_control u_control (
        .clk          (clk),
        .reset        (reset),
        .i_mem_read   (bus.mem_read),
        .i_mem_write  (bus.mem_write),
        .i_word_resp  (bus.word_resp),
        .o_idx        (w_idx),
        .o_load_req   (w_load_req),
        .o_load_wdata (w_load_wdata),
        .o_store_word (w_store_word),
        .o_word_read  (w_word_read),
        .o_word_write (w_word_write),
        .o_mem_resp   (w_mem_resp)
    );

    // Offset bits of the request address are dropped at acceptance.
    assign w_line_base = bus.mem_address & 16'hFFF0;

    // Line base address, captured when a request is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base <= '0;
        end else if (w_load_req) begin
            r_base <= w_line_base;
        end
    end

    // Write line, captured when a write is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdata <= '0;
        end else if (w_load_wdata) begin
            r_wdata <= bus.mem_wdata;
        end
    end

    // Read line buffer, filled one word slot per completed read word.
    always_ff @(posedge clk) begin
        // NOTE: the buffer is reset on purpose: mem_rdata is visible at all
        // times and must read as zero after reset, not stale line data.
        if (reset) begin
            r_buffer <= '0;
        end else if (w_store_word) begin
            r_buffer[{w_idx, 4'b0000} +: 16] <= bus.word_rdata;
        end
    end

    // Word-port outputs decode only from registered state, so they are
    // stable for the whole cycle.
    assign bus.word_address = line_word_address(r_base, w_idx);
    assign bus.word_wdata   = r_wdata[{w_idx, 4'b0000} +: 16];
    assign bus.word_read    = w_word_read;
    assign bus.word_write   = w_word_write;
    assign bus.mem_resp     = w_mem_resp;
    assign bus.mem_rdata    = r_buffer;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench for l2_mem_responder with a wait-state word memory model.
module tb_l2_mem_responder;
    import l2_mem_responder_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    l2_mem_responder_if bus ();

    l2_mem_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Word memory model: answers after n_wait idle cycles, read data is
    // rd_base + word index; write cycles return a junk pattern.
    bit       mem_en  = 1'b1;
    int       n_wait  = 0;
    int       wait_cnt = 0;
    lc3b_word rd_base = 16'h0000;
    lc3b_word log_addr[$];
    lc3b_word log_data[$];
    bit       log_wr[$];

    // Per-cycle observation of one line transaction.
    bit       trace_act[$];
    lc3b_word trace_addr[$];

    always @(negedge clk) begin
        if (mem_en) begin
            if (bus.word_read || bus.word_write) begin
                if (wait_cnt >= n_wait) begin
                    bus.word_resp  = 1'b1;
                    bus.word_rdata = bus.word_read ? (rd_base + {13'b0, bus.word_address[3:1]})
                                                   : 16'hDEAD;
                    log_addr.push_back(bus.word_address);
                    log_data.push_back(bus.word_wdata);
                    log_wr.push_back(bus.word_write);
                    wait_cnt = 0;
                end else begin
                    bus.word_resp = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.word_resp = 1'b0;
                wait_cnt = 0;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one line request in the current (IDLE) cycle and follow it until
    // two cycles past the drop point. lat is the cycle offset of mem_resp.
    task automatic do_line(input lc3b_word addr, input logic rd, input logic wr,
                           input lc3b_c_line wdata, input int hold, input int budget,
                           output int lat, output lc3b_c_line line, output int n_resp);
        lat    = -1;
        n_resp = 0;
        line   = '0;
        trace_act.delete();
        trace_addr.delete();
        log_addr.delete();
        log_data.delete();
        log_wr.delete();
        bus.mem_address = addr;
        bus.mem_wdata   = wdata;
        bus.mem_read    = rd;
        bus.mem_write   = wr;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (k == 1) begin
                bus.mem_address = ~addr;
                bus.mem_wdata   = ~wdata;
            end
            trace_act.push_back(bus.word_read || bus.word_write);
            trace_addr.push_back(bus.word_address);
            if (bus.mem_resp === 1'b1) begin
                n_resp++;
                if (lat < 0) begin
                    lat  = k;
                    line = bus.mem_rdata;
                end
            end
            if (lat >= 0 && k == lat + hold) begin
                bus.mem_read  = 1'b0;
                bus.mem_write = 1'b0;
            end
            if (lat >= 0 && k >= lat + hold + 2) break;
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = '0;
        bus.mem_wdata   = '0;
        bus.word_resp   = 1'b0;
        bus.word_rdata  = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (bus.mem_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mem_resp: got %b expected 0", bus.mem_resp);
        end
        n_checks++;
        if (bus.mem_rdata !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_mem_rdata: got %h expected 0", bus.mem_rdata);
        end
        n_checks++;
        if ({bus.word_read, bus.word_write} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_word_rw: got %b expected 00", {bus.word_read, bus.word_write});
        end
        n_checks++;
        if (bus.word_address !== 16'h0 || bus.word_wdata !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_word_addr_data: got %h/%h expected 0000/0000",
                     bus.word_address, bus.word_wdata);
        end
    endtask

    task automatic test_read_zero_wait();
        int lat, n_resp;
        lc3b_c_line line;
        n_wait  = 0;
        rd_base = 16'hA000;
        do_line(16'h1230, 1'b1, 1'b0, '0, 0, 60, lat, line, n_resp);
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL read0_latency: got %0d expected 9", lat);
        end
        n_checks++;
        if (line !== 128'hA007_A006_A005_A004_A003_A002_A001_A000) begin
            n_fail++;
            $display("FAIL read0_rdata: got %h expected a007a006a005a004a003a002a001a000", line);
        end
        n_checks++;
        if (n_resp !== 1) begin
            n_fail++;
            $display("FAIL read0_resp_count: got %0d expected 1", n_resp);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (trace_addr.size() <= i || trace_addr[i] !== 16'h1230 + 16'(2 * i)) begin
                n_fail++;
                $display("FAIL read0_word_addr[%0d]: got %h expected %h", i,
                         (trace_addr.size() > i) ? trace_addr[i] : 16'hxxxx, 16'h1230 + 16'(2 * i));
            end
        end
        n_checks++;
        if (log_addr.size() !== 8) begin
            n_fail++;
            $display("FAIL read0_word_count: got %0d expected 8", log_addr.size());
        end
    endtask

    task automatic test_write();
        int lat, n_resp;
        lc3b_c_line line;
        n_wait  = 0;
        do_line(16'h4448, 1'b0, 1'b1, 128'h0077_0066_0055_0044_0033_0022_0011_0000,
                0, 60, lat, line, n_resp);
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL write_latency: got %0d expected 9", lat);
        end
        n_checks++;
        if (log_addr.size() !== 8) begin
            n_fail++;
            $display("FAIL write_word_count: got %0d expected 8", log_addr.size());
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (log_addr.size() <= i || log_addr[i] !== 16'h4440 + 16'(2 * i) ||
                log_data[i] !== 16'(16'h0011 * i) || log_wr[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL write_word[%0d]: got addr %h data %h wr %b expected addr %h data %h wr 1",
                         i, (log_addr.size() > i) ? log_addr[i] : 16'hxxxx,
                         (log_data.size() > i) ? log_data[i] : 16'hxxxx,
                         (log_wr.size() > i) ? log_wr[i] : 1'bx,
                         16'h4440 + 16'(2 * i), 16'(16'h0011 * i));
            end
        end
        n_checks++;
        if (line !== 128'hA007_A006_A005_A004_A003_A002_A001_A000) begin
            n_fail++;
            $display("FAIL write_buffer_kept: got %h expected a007a006a005a004a003a002a001a000", line);
        end
    endtask

    task automatic test_read_two_wait();
        int lat, n_resp;
        lc3b_c_line line;
        n_wait  = 2;
        rd_base = 16'hB000;
        do_line(16'h0150, 1'b1, 1'b0, '0, 0, 100, lat, line, n_resp);
        n_wait  = 0;
        n_checks++;
        if (lat !== 25) begin
            n_fail++;
            $display("FAIL wait2_latency: got %0d expected 25", lat);
        end
        n_checks++;
        if (line !== 128'hB007_B006_B005_B004_B003_B002_B001_B000) begin
            n_fail++;
            $display("FAIL wait2_rdata: got %h expected b007b006b005b004b003b002b001b000", line);
        end
        for (int k = 1; k <= 24; k++) begin
            n_checks++;
            if (trace_act.size() < k || trace_act[k-1] !== 1'b1 ||
                trace_addr[k-1] !== 16'h0150 + 16'(2 * ((k - 1) / 3))) begin
                n_fail++;
                $display("FAIL wait2_cycle[%0d]: got rd %b addr %h expected rd 1 addr %h", k,
                         (trace_act.size() >= k) ? trace_act[k-1] : 1'bx,
                         (trace_addr.size() >= k) ? trace_addr[k-1] : 16'hxxxx,
                         16'h0150 + 16'(2 * ((k - 1) / 3)));
            end
        end
    endtask

    task automatic test_held_through_done();
        int lat, n_resp;
        lc3b_c_line line;
        rd_base = 16'hC000;
        do_line(16'h2000, 1'b1, 1'b0, '0, 2, 60, lat, line, n_resp);
        n_checks++;
        if (lat !== 9 || n_resp !== 1) begin
            n_fail++;
            $display("FAIL held_resp: got lat %0d count %0d expected lat 9 count 1", lat, n_resp);
        end
        n_checks++;
        if (line !== 128'hC007_C006_C005_C004_C003_C002_C001_C000) begin
            n_fail++;
            $display("FAIL held_rdata: got %h expected c007c006c005c004c003c002c001c000", line);
        end
        for (int k = 10; k <= 13; k++) begin
            n_checks++;
            if (trace_act.size() < k || trace_act[k-1] !== 1'b0) begin
                n_fail++;
                $display("FAIL held_no_restart[%0d]: got %b expected 0", k,
                         (trace_act.size() >= k) ? trace_act[k-1] : 1'bx);
            end
        end
    endtask

    task automatic test_read_write_both();
        int lat, n_resp;
        lc3b_c_line line;
        do_line(16'h3006, 1'b1, 1'b1, 128'h8888_7777_6666_5555_4444_3333_2222_1111,
                0, 60, lat, line, n_resp);
        n_checks++;
        if (lat !== 9 || log_wr.size() !== 8) begin
            n_fail++;
            $display("FAIL both_burst: got lat %0d words %0d expected lat 9 words 8", lat, log_wr.size());
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (log_wr.size() <= i || log_wr[i] !== 1'b1 || log_addr[i] !== 16'h3000 + 16'(2 * i) ||
                log_data[i] !== 16'(16'h1111 * (i + 1))) begin
                n_fail++;
                $display("FAIL both_word[%0d]: got wr %b addr %h data %h expected wr 1 addr %h data %h", i,
                         (log_wr.size() > i) ? log_wr[i] : 1'bx,
                         (log_addr.size() > i) ? log_addr[i] : 16'hxxxx,
                         (log_data.size() > i) ? log_data[i] : 16'hxxxx,
                         16'h3000 + 16'(2 * i), 16'(16'h1111 * (i + 1)));
            end
        end
        n_checks++;
        if (line !== 128'hC007_C006_C005_C004_C003_C002_C001_C000) begin
            n_fail++;
            $display("FAIL both_buffer_kept: got %h expected c007c006c005c004c003c002c001c000", line);
        end
    endtask

    task automatic test_reset_mid_read();
        int lat, n_resp;
        lc3b_c_line line;
        rd_base         = 16'hD000;
        bus.mem_address = 16'h0500;
        bus.mem_read    = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        n_checks++;
        if (bus.word_read !== 1'b1 || bus.word_address !== 16'h0508) begin
            n_fail++;
            $display("FAIL abort_at_word4: got rd %b addr %h expected rd 1 addr 0508",
                     bus.word_read, bus.word_address);
        end
        reset        = 1'b1;
        bus.mem_read = 1'b0;
        tick();
        reset          = 1'b0;
        mem_en         = 1'b0;
        bus.word_resp  = 1'b1;
        bus.word_rdata = 16'hFFFF;
        n_checks++;
        if ({bus.word_read, bus.word_write, bus.mem_resp} !== 3'b000 ||
            bus.word_address !== 16'h0 || bus.word_wdata !== 16'h0 || bus.mem_rdata !== 128'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: got rd %b wr %b resp %b addr %h wdata %h rdata %h expected all 0",
                     bus.word_read, bus.word_write, bus.mem_resp, bus.word_address,
                     bus.word_wdata, bus.mem_rdata);
        end
        tick();
        bus.word_resp = 1'b0;
        tick();
        n_checks++;
        if ({bus.word_read, bus.word_write, bus.mem_resp} !== 3'b000 ||
            bus.word_address !== 16'h0 || bus.mem_rdata !== 128'h0) begin
            n_fail++;
            $display("FAIL abort_stray_resp: got rd %b wr %b resp %b addr %h rdata %h expected all 0",
                     bus.word_read, bus.word_write, bus.mem_resp, bus.word_address, bus.mem_rdata);
        end
        mem_en  = 1'b1;
        rd_base = 16'hE000;
        do_line(16'h0600, 1'b1, 1'b0, '0, 0, 60, lat, line, n_resp);
        n_checks++;
        if (lat !== 9 || n_resp !== 1) begin
            n_fail++;
            $display("FAIL abort_fresh_resp: got lat %0d count %0d expected lat 9 count 1", lat, n_resp);
        end
        n_checks++;
        if (line !== 128'hE007_E006_E005_E004_E003_E002_E001_E000) begin
            n_fail++;
            $display("FAIL abort_fresh_rdata: got %h expected e007e006e005e004e003e002e001e000", line);
        end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write();
        test_read_two_wait();
        test_held_through_done();
        test_read_write_both();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
